// File: rtl/loop_track.sv
// rtl/loop_track.sv - loop-counter frame receiver: recovers in-frame index, counts frames, flags framing errors

module loop_track #(
    parameter int    DATA_W = 8,
    parameter int    FRM_W  = 16,
    parameter string MODE   = "strict"
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] lim,
    input  logic              clr,
    input  logic              in_valid,
    input  logic              in_last,
    output logic [DATA_W-1:0] idx,
    output logic              idx_valid,
    output logic              frm_done,
    output logic [FRM_W-1:0]  frm_cnt,
    output logic              err_early,
    output logic              err_late,
    output logic              err_sticky,
    output logic              busy
);

    localparam bit                RESYNC   = (MODE == "resync");
    localparam logic [DATA_W-1:0] POS_ONE  = 1;
    localparam logic [FRM_W-1:0]  FRM_ONE  = 1;

    typedef enum logic {RUN, SYNC} state_t;

    state_t            state;
    logic [DATA_W-1:0] pos;
    logic [DATA_W-1:0] lim_q;
    logic [DATA_W-1:0] l_cur;

    // The first beat of a frame must be judged against the limit it latches.
    assign l_cur = (pos == '0) ? lim : lim_q;
    assign busy  = (pos != '0) || (state == SYNC);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state      <= RUN;
            pos        <= '0;
            lim_q      <= '0;
            idx        <= '0;
            idx_valid  <= 1'b0;
            frm_done   <= 1'b0;
            frm_cnt    <= '0;
            err_early  <= 1'b0;
            err_late   <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            idx_valid <= 1'b0;
            frm_done  <= 1'b0;
            err_early <= 1'b0;
            err_late  <= 1'b0;
            if (in_valid) begin
                if (state == RUN) begin
                    idx       <= pos;
                    idx_valid <= 1'b1;
                    if (pos == '0) begin
                        lim_q <= lim;
                    end
                    if (pos < l_cur) begin
                        if (in_last) begin
                            err_early  <= 1'b1;
                            err_sticky <= 1'b1;
                            pos        <= '0;
                        end else begin
                            pos <= pos + POS_ONE;
                        end
                    end else begin
                        pos <= '0;
                        if (in_last) begin
                            frm_done <= 1'b1;
                            frm_cnt  <= frm_cnt + FRM_ONE;
                        end else begin
                            err_late   <= 1'b1;
                            err_sticky <= 1'b1;
                            if (RESYNC) begin
                                state <= SYNC;
                            end
                        end
                    end
                end else if (in_last) begin
                    // Dropped beats until the upstream frame boundary; restart at index 0.
                    state <= RUN;
                end
            end
        end
    end

endmodule

// File: tb/tb_loop_track.sv
// tb/tb_loop_track.sv - scoreboard bench for loop_track (strict, resync and 2-bit counter builds)

module tb_loop_track;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [7:0] lim = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;

    logic [7:0]  idx_s, idx_r, idx_w;
    logic        iv_s, iv_r, iv_w;
    logic        fd_s, fd_r, fd_w;
    logic [15:0] fc_s, fc_r;
    logic [1:0]  fc_w;
    logic        ee_s, ee_r, ee_w;
    logic        el_s, el_r, el_w;
    logic        st_s, st_r, st_w;
    logic        bz_s, bz_r, bz_w;

    always #5 clk = ~clk;

    loop_track #(.DATA_W(8), .FRM_W(16), .MODE("strict")) u_strict (
        .clk(clk), .rst(rst), .lim(lim), .clr(clr), .in_valid(in_valid), .in_last(in_last),
        .idx(idx_s), .idx_valid(iv_s), .frm_done(fd_s), .frm_cnt(fc_s), .err_early(ee_s),
        .err_late(el_s), .err_sticky(st_s), .busy(bz_s));

    loop_track #(.DATA_W(8), .FRM_W(16), .MODE("resync")) u_resync (
        .clk(clk), .rst(rst), .lim(lim), .clr(clr), .in_valid(in_valid), .in_last(in_last),
        .idx(idx_r), .idx_valid(iv_r), .frm_done(fd_r), .frm_cnt(fc_r), .err_early(ee_r),
        .err_late(el_r), .err_sticky(st_r), .busy(bz_r));

    loop_track #(.DATA_W(8), .FRM_W(2), .MODE("strict")) u_wrap (
        .clk(clk), .rst(rst), .lim(lim), .clr(clr), .in_valid(in_valid), .in_last(in_last),
        .idx(idx_w), .idx_valid(iv_w), .frm_done(fd_w), .frm_cnt(fc_w), .err_early(ee_w),
        .err_late(el_w), .err_sticky(st_w), .busy(bz_w));

    typedef struct {
        int cyc;
        int sel;
        bit xv;
        int xi;
        bit xd;
        bit xe;
        bit xl;
        int xc;
        bit xs;
        bit xb;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   cur_sel = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare the selected build's outputs against the expectation due this cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            bit   av, ad, ae, al, as, ab;
            int   ai, ac;
            e = q.pop_front();
            case (e.sel)
                0:       begin av = iv_s; ai = int'(idx_s); ad = fd_s; ae = ee_s; al = el_s; ac = int'(fc_s); as = st_s; ab = bz_s; end
                1:       begin av = iv_r; ai = int'(idx_r); ad = fd_r; ae = ee_r; al = el_r; ac = int'(fc_r); as = st_r; ab = bz_r; end
                default: begin av = iv_w; ai = int'(idx_w); ad = fd_w; ae = ee_w; al = el_w; ac = int'(fc_w); as = st_w; ab = bz_w; end
            endcase
            n_chk++;
            if (av == e.xv && ai == e.xi && ad == e.xd && ae == e.xe && al == e.xl &&
                ac == e.xc && as == e.xs && ab == e.xb) begin
                n_pass++;
            end else begin
                $display("FAIL beat cyc=%0d sel=%0d got v=%0d idx=%0d done=%0d early=%0d late=%0d cnt=%0d sticky=%0d busy=%0d want v=%0d idx=%0d done=%0d early=%0d late=%0d cnt=%0d sticky=%0d busy=%0d",
                         e.cyc, e.sel, av, ai, ad, ae, al, ac, as, ab,
                         e.xv, e.xi, e.xd, e.xe, e.xl, e.xc, e.xs, e.xb);
            end
        end
    end

    task automatic go(input bit v, input bit l, input bit xv, input int xi, input bit xd,
                      input bit xe, input bit xl, input int xc, input bit xs, input bit xb);
        exp_t e;
        in_valid = v;
        in_last  = l;
        e.cyc = cyc + 1;
        e.sel = cur_sel;
        e.xv = xv; e.xi = xi; e.xd = xd; e.xe = xe; e.xl = xl;
        e.xc = xc; e.xs = xs; e.xb = xb;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        go(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        clr = 1'b0;
    endtask

    initial begin
        // Reset state, with a beat that must be dropped.
        rst = 1'b1;
        go(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Two clean frames of 4 beats.
        cur_sel = 0; lim = 8'd3;
        go(1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        go(1, 0, 1, 1, 0, 0, 0, 0, 0, 1);
        go(1, 0, 1, 2, 0, 0, 0, 0, 0, 1);
        go(1, 1, 1, 3, 1, 0, 0, 1, 0, 0);
        go(1, 0, 1, 0, 0, 0, 0, 1, 0, 1);
        go(1, 0, 1, 1, 0, 0, 0, 1, 0, 1);
        go(1, 0, 1, 2, 0, 0, 0, 1, 0, 1);
        go(1, 1, 1, 3, 1, 0, 0, 2, 0, 0);
        go(0, 0, 0, 3, 0, 0, 0, 2, 0, 0);

        // Early last.
        do_clr();
        go(1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        go(1, 1, 1, 1, 0, 1, 0, 0, 1, 0);
        go(1, 0, 1, 0, 0, 0, 0, 0, 1, 1);
        go(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        do_clr();

        // Strict missing last.
        lim = 8'd2;
        go(1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        go(1, 0, 1, 1, 0, 0, 0, 0, 0, 1);
        go(1, 0, 1, 2, 0, 0, 1, 0, 1, 0);
        go(1, 0, 1, 0, 0, 0, 0, 0, 1, 1);
        go(1, 0, 1, 1, 0, 0, 0, 0, 1, 1);
        go(1, 0, 1, 2, 0, 0, 1, 0, 1, 0);
        do_clr();

        // Resync build: one error, three dropped beats, then a clean frame.
        cur_sel = 1;
        go(1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        go(1, 0, 1, 1, 0, 0, 0, 0, 0, 1);
        go(1, 0, 1, 2, 0, 0, 1, 0, 1, 1);
        go(1, 0, 0, 2, 0, 0, 0, 0, 1, 1);
        go(1, 0, 0, 2, 0, 0, 0, 0, 1, 1);
        go(1, 1, 0, 2, 0, 0, 0, 0, 1, 0);
        go(1, 0, 1, 0, 0, 0, 0, 0, 1, 1);
        go(1, 0, 1, 1, 0, 0, 0, 0, 1, 1);
        go(1, 1, 1, 2, 1, 0, 0, 1, 1, 0);
        do_clr();

        // lim==0 single-beat frames, then mid-frame lim change.
        cur_sel = 0; lim = 8'd0;
        for (int i = 1; i <= 4; i++) go(1, 1, 1, 0, 1, 0, 0, i, 0, 0);
        go(1, 0, 1, 0, 0, 0, 1, 4, 1, 0);
        lim = 8'd3;
        go(1, 0, 1, 0, 0, 0, 0, 4, 1, 1);
        go(1, 0, 1, 1, 0, 0, 0, 4, 1, 1);
        lim = 8'd1;
        go(1, 0, 1, 2, 0, 0, 0, 4, 1, 1);
        go(1, 1, 1, 3, 1, 0, 0, 5, 1, 0);
        go(1, 0, 1, 0, 0, 0, 0, 5, 1, 1);
        go(1, 1, 1, 1, 1, 0, 0, 6, 1, 0);

        // clr mid-frame with a coincident beat.
        lim = 8'd3;
        go(1, 0, 1, 0, 0, 0, 0, 6, 1, 1);
        go(1, 0, 1, 1, 0, 0, 0, 6, 1, 1);
        clr = 1'b1;
        go(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        clr = 1'b0;

        // 2-bit frame counter wrap.
        cur_sel = 2; lim = 8'd0;
        for (int i = 1; i <= 5; i++) go(1, 1, 1, 0, 1, 0, 0, i % 4, 0, 0);
        in_valid = 1'b0;
        in_last  = 1'b0;

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_chk++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
